// File: rtl/fp24_pkg.sv
// Shared 24-bit floating-point word layout: {sign, exp (offset 63), frac (hidden 1)}.
package fp24_pkg;

  localparam int unsigned FP_W     = 24;
  localparam int unsigned EXP_W    = 7;
  localparam int unsigned FRAC_W   = 16;
  localparam int unsigned EXP_BIAS = 63;

  localparam int unsigned SIGN_BIT = 23;
  localparam int unsigned EXP_MSB  = 22;
  localparam int unsigned EXP_LSB  = 16;
  localparam int unsigned FRAC_MSB = 15;
  localparam int unsigned FRAC_LSB = 0;

  typedef logic [FP_W-1:0] fp24_t;

  function automatic logic is_zero(input fp24_t x);
    return (x[EXP_MSB:EXP_LSB] == '0) && (x[FRAC_MSB:FRAC_LSB] == '0);
  endfunction

endpackage

// File: rtl/fpmul_arbiter_if.sv
// Requester, datapath and response signals of the shared FP multiplier arbiter.
interface fpmul_arbiter_if
  import fp24_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) ();

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*FP_W-1:0] req_a;
  logic [NREQ*FP_W-1:0] req_b;
  fp24_t                mul_a;
  fp24_t                mul_b;
  fp24_t                mul_res;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  fp24_t                rsp_data;
  logic                 busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_res, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_res, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/fpmul_rsp_fifo.sv
// Response FIFO: registered write, combinational head, push and pop allowed together at any fill.
module fpmul_rsp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 26
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop, full;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign valid_o = (cnt_q != '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign pop     = pop_i && valid_o;
  assign head_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

  always_comb begin
    wr_d  = push_i ? bump(wr_q) : wr_q;
    rd_d  = pop ? bump(rd_q) : rd_q;
    cnt_d = cnt_q;
    case ({push_i, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // When full, wr_q == rd_q: a same-edge push overwrites the slot being popped.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full && !pop));

endmodule

// File: rtl/fpmul_arbiter.sv
// Round-robin, credit-gated sequencer sharing one fixed-latency FP multiplier among NREQ requesters.
module fpmul_arbiter
  import fp24_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDW   = 2
) (
  input logic            clk,
  input logic            rst,
  fpmul_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(LAT + 1);
  localparam int unsigned RW = IDW + FP_W;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
    logic           zero;
    logic           sgn;
  } tag_t;

  logic [IDW-1:0] rr_q, rr_d;
  tag_t           tag_q [LAT];
  tag_t           tag_d;
  logic [IW-1:0]  inflight;
  logic [CW-1:0]  fifo_cnt;
  logic           credit, gnt_vld, fifo_vld, push;
  logic [IDW-1:0] gnt_idx, idx;
  fp24_t          a_arr [NREQ];
  fp24_t          b_arr [NREQ];
  fp24_t          op_a, op_b;
  logic [RW-1:0]  push_data, head;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < LAT; i++) inflight = inflight + IW'(tag_q[i].vld);
  end

  // Reserve a FIFO slot for every tag in flight; the datapath cannot be stalled.
  assign credit = rst && ((32'(fifo_cnt) + 32'(inflight)) < DEPTH);

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      a_arr[i] = bus.req_a[i*FP_W +: FP_W];
      b_arr[i] = bus.req_b[i*FP_W +: FP_W];
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(rr_q) + k) % NREQ);
      if (credit && !gnt_vld && bus.req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign op_a          = gnt_vld ? a_arr[gnt_idx] : '0;
  assign op_b          = gnt_vld ? b_arr[gnt_idx] : '0;
  assign bus.mul_a     = op_a;
  assign bus.mul_b     = op_b;
  assign bus.req_ready = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    tag_d.vld  = gnt_vld;
    tag_d.id   = gnt_idx;
    tag_d.zero = gnt_vld && (is_zero(op_a) || is_zero(op_b));
    tag_d.sgn  = op_a[SIGN_BIT] ^ op_b[SIGN_BIT];
    rr_d       = rr_q;
    if (gnt_vld) rr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      rr_q     <= rr_d;
      tag_q[0] <= tag_d;
      for (int unsigned i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign push      = tag_q[LAT-1].vld;
  assign push_data = {tag_q[LAT-1].id,
                      tag_q[LAT-1].zero ? {tag_q[LAT-1].sgn, {(FP_W-1){1'b0}}} : bus.mul_res};

  fpmul_rsp_fifo #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (bus.rsp_ready),
    .valid_o (fifo_vld),
    .head_o  (head),
    .count_o (fifo_cnt)
  );

  assign bus.rsp_valid = fifo_vld;
  assign bus.rsp_id    = head[RW-1:FP_W];
  assign bus.rsp_data  = head[FP_W-1:0];
  assign bus.busy      = (inflight != '0) || fifo_vld;

endmodule
